// File: rtl/fpga_bram_req_ctrl_if.sv
// Request, BRAM-port and response signals of fpga_bram_req_ctrl bundled together.
// The slave modport is the controller's view; master is the requester/BRAM side.
interface fpga_bram_req_ctrl_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 32,
    parameter int RSP_DEPTH     = 4
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic [ADDRESS_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0]    dina;
    logic                     wea;
    logic                     ena;
    logic [DATA_WIDTH-1:0]    douta;
    logic                     error;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_error;
    logic [CNT_W-1:0]         rd_outstanding;
    logic                     err_sticky;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, douta, error, rsp_ready,
        output req_ready, addra, dina, wea, ena, rsp_valid, rsp_rdata, rsp_error,
               rd_outstanding, err_sticky
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, douta, error, rsp_ready,
        input  req_ready, addra, dina, wea, ena, rsp_valid, rsp_rdata, rsp_error,
               rd_outstanding, err_sticky
    );
endinterface

// File: rtl/fpga_bram_req_ctrl.sv
// Credit-limited request controller for a pipelined BRAM port: registered BRAM
// drive, valid-bit return tracking and an in-order response FIFO.
module fpga_bram_req_ctrl #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 32,
    parameter int READ_LATENCY  = 2,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fpga_bram_req_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic                     r_live;
    logic [CNT_W-1:0]         r_outst;
    logic                     r_ena;
    logic                     r_wea;
    logic [ADDRESS_WIDTH-1:0] r_addra;
    logic [DATA_WIDTH-1:0]    r_dina;
    logic [READ_LATENCY-1:0]  r_vsr;
    logic [DATA_WIDTH:0]      r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [CNT_W-1:0]         r_fcnt;
    logic                     r_err_sticky;

    logic w_ready;
    logic w_accept;
    logic w_rd_accept;
    logic w_push;
    logic w_rsp_valid;
    logic w_pop;

    // r_live keeps req_ready low through reset while staying purely registered
    assign w_ready     = r_live & (r_outst < CNT_W'(RSP_DEPTH));
    assign w_accept    = bus.req_valid & w_ready;
    assign w_rd_accept = w_accept & ~bus.req_we;
    assign w_push      = r_vsr[READ_LATENCY-1];
    assign w_rsp_valid = (r_fcnt != '0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= 1'b0;
            r_ena   <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
            r_outst <= '0;
        end else begin
            r_live <= 1'b1;
            r_ena  <= w_accept;
            r_wea  <= w_accept & bus.req_we;
            if (w_accept) begin
                r_addra <= bus.req_addr;
                r_dina  <= bus.req_wdata;
            end
            case ({w_rd_accept, w_pop})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Stage k is high during cycle E+k+1 for a read enabled in cycle E
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsr <= '0;
        end else begin
            r_vsr[0] <= r_ena & ~r_wea;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_vsr[i] <= r_vsr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.error, bus.douta};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_fcnt       <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_push && bus.error) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    a_rsp_fifo_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_fcnt == CNT_W'(RSP_DEPTH)))
    ) else $error("response FIFO push while full");

    assign bus.req_ready      = w_ready;
    assign bus.ena            = r_ena;
    assign bus.wea            = r_wea;
    assign bus.addra          = r_addra;
    assign bus.dina           = r_dina;
    assign bus.rsp_valid      = w_rsp_valid;
    assign bus.rsp_rdata      = w_rsp_valid ? r_mem[r_rptr][DATA_WIDTH-1:0] : '0;
    assign bus.rsp_error      = w_rsp_valid ? r_mem[r_rptr][DATA_WIDTH] : 1'b0;
    assign bus.rd_outstanding = r_outst;
    assign bus.err_sticky     = r_err_sticky;
endmodule
